// File: rtl/regdst_pipe_tracker.sv
// regdst_pipe_tracker
// Decodes the write-destination register of the instruction leaving D from
// its RegDst mode, then carries destination, write enable and remaining Tnew
// through STAGES pipeline slots (slot 0 = E ... slot STAGES-1 = W).
// Exposes per-slot state for the hazard unit and a combinational forwarding
// lookup that prefers the youngest matching slot.
// Optional build macro: REGDST_PIPE_STATS_EN adds stat_bubbles/stat_flushes
// event counters; without it those ports and counters do not exist.
module regdst_pipe_tracker #(
  parameter int ADDR_W   = 5,
  parameter int STAGES   = 3,
  parameter int TNEW_W   = 2,
  parameter int LINK_REG = 31
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       stall,
  input  logic                       flush,
  input  logic                       in_valid,
  input  logic [1:0]                 in_regdst,
  input  logic [ADDR_W-1:0]          in_rt,
  input  logic [ADDR_W-1:0]          in_rd,
  input  logic [TNEW_W-1:0]          in_tnew,
  input  logic [ADDR_W-1:0]          query_addr,
  output logic [STAGES*ADDR_W-1:0]   out_a3,
  output logic [STAGES-1:0]          out_we,
  output logic [STAGES*TNEW_W-1:0]   out_tnew,
  output logic                       hit,
  output logic [2:0]                 hit_slot,
  output logic                       hit_ready
`ifdef REGDST_PIPE_STATS_EN
  ,
  output logic [31:0]                stat_bubbles,
  output logic [31:0]                stat_flushes
`endif
);

  localparam logic [1:0] MODE_RT   = 2'd0;
  localparam logic [1:0] MODE_RD   = 2'd1;
  localparam logic [1:0] MODE_LINK = 2'd2;

  // Per-slot state
  logic [ADDR_W-1:0] a3_q   [STAGES];
  logic [ADDR_W-1:0] a3_d   [STAGES];
  logic              we_q   [STAGES];
  logic              we_d   [STAGES];
  logic [TNEW_W-1:0] tnew_q [STAGES];
  logic [TNEW_W-1:0] tnew_d [STAGES];

  // Decoded slot-0 candidate
  logic [ADDR_W-1:0] dec_a3;
  logic              dec_we;

  // One cycle of progress on Tnew; holds at zero so a ready result stays ready.
  function automatic logic [TNEW_W-1:0] tnew_step(input logic [TNEW_W-1:0] t);
    return (t == '0) ? '0 : t - TNEW_W'(1);
  endfunction

  // Destination decode from RegDst mode; $0 is recorded but never written.
  always_comb begin
    dec_a3 = '0;
    case (in_regdst)
      MODE_RT:   dec_a3 = in_rt;
      MODE_RD:   dec_a3 = in_rd;
      MODE_LINK: dec_a3 = ADDR_W'(LINK_REG);
      default:   dec_a3 = '0;
    endcase
    dec_we = in_valid && (in_regdst != 2'd3) && (dec_a3 != '0);
  end

  // Next-state for every slot: flush beats stall beats normal advance.
  always_comb begin
    for (int i = 0; i < STAGES; i++) begin
      a3_d[i]   = a3_q[i];
      we_d[i]   = we_q[i];
      tnew_d[i] = tnew_q[i];
    end
    if (flush) begin
      for (int i = 0; i < STAGES; i++) begin
        a3_d[i]   = '0;
        we_d[i]   = 1'b0;
        tnew_d[i] = '0;
      end
    end else begin
      for (int i = 1; i < STAGES; i++) begin
        a3_d[i]   = a3_q[i-1];
        we_d[i]   = we_q[i-1];
        tnew_d[i] = tnew_step(tnew_q[i-1]);
      end
      if (stall) begin
        a3_d[0]   = '0;
        we_d[0]   = 1'b0;
        tnew_d[0] = '0;
      end else begin
        a3_d[0]   = dec_a3;
        we_d[0]   = dec_we;
        tnew_d[0] = in_tnew;
      end
    end
  end

  // Slot registers; asynchronous clear so a mid-cycle reset empties the pipe at once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < STAGES; i++) begin
        a3_q[i]   <= '0;
        we_q[i]   <= 1'b0;
        tnew_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < STAGES; i++) begin
        a3_q[i]   <= a3_d[i];
        we_q[i]   <= we_d[i];
        tnew_q[i] <= tnew_d[i];
      end
    end
  end

  // Flatten slot state onto the packed output buses.
  always_comb begin
    out_a3   = '0;
    out_we   = '0;
    out_tnew = '0;
    for (int i = 0; i < STAGES; i++) begin
      out_a3[i*ADDR_W +: ADDR_W]   = a3_q[i];
      out_we[i]                    = we_q[i];
      out_tnew[i*TNEW_W +: TNEW_W] = tnew_q[i];
    end
  end

  // Forwarding lookup: youngest writing slot whose destination matches wins.
  always_comb begin
    hit       = 1'b0;
    hit_slot  = 3'd0;
    hit_ready = 1'b0;
    if (query_addr != '0) begin
      for (int i = 0; i < STAGES; i++) begin
        if (!hit && we_q[i] && (a3_q[i] == query_addr)) begin
          hit       = 1'b1;
          hit_slot  = 3'(i);
          hit_ready = (tnew_q[i] == '0);
        end
      end
    end
  end

`ifdef REGDST_PIPE_STATS_EN
  logic [31:0] bubbles_q;
  logic [31:0] bubbles_d;
  logic [31:0] flushes_q;
  logic [31:0] flushes_d;

  // Event counters; wrap naturally at 2^32.
  always_comb begin
    bubbles_d = bubbles_q;
    flushes_d = flushes_q;
    if (flush) begin
      flushes_d = flushes_q + 32'd1;
    end else if (stall) begin
      bubbles_d = bubbles_q + 32'd1;
    end
  end

  // Counter registers share the pipeline's asynchronous clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bubbles_q <= '0;
      flushes_q <= '0;
    end else begin
      bubbles_q <= bubbles_d;
      flushes_q <= flushes_d;
    end
  end

  assign stat_bubbles = bubbles_q;
  assign stat_flushes = flushes_q;
`endif

endmodule

// File: tb/tb_regdst_pipe_tracker.sv
// Self-checking bench for regdst_pipe_tracker. The reference keeps a history
// of the instructions that entered slot 0 on each of the last STAGES edges
// (bubbles included); the expected Tnew of slot k is max(0, tnew_at_entry - k).
module tb_regdst_pipe_tracker;
  localparam int AW = 5;
  localparam int ST = 3;
  localparam int TW = 2;
  localparam int LINK = 31;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              stall = 1'b0;
  logic              flush = 1'b0;
  logic              in_valid = 1'b0;
  logic [1:0]        in_regdst = 2'd3;
  logic [AW-1:0]     in_rt = '0;
  logic [AW-1:0]     in_rd = '0;
  logic [TW-1:0]     in_tnew = '0;
  logic [AW-1:0]     query_addr = '0;
  logic [ST*AW-1:0]  out_a3;
  logic [ST-1:0]     out_we;
  logic [ST*TW-1:0]  out_tnew;
  logic              hit;
  logic [2:0]        hit_slot;
  logic              hit_ready;
`ifdef REGDST_PIPE_STATS_EN
  logic [31:0]       stat_bubbles;
  logic [31:0]       stat_flushes;
  int unsigned       m_bubbles = 0;
  int unsigned       m_flushes = 0;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  regdst_pipe_tracker #(.ADDR_W(AW), .STAGES(ST), .TNEW_W(TW), .LINK_REG(LINK)) dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .in_valid(in_valid),
    .in_regdst(in_regdst), .in_rt(in_rt), .in_rd(in_rd), .in_tnew(in_tnew),
    .query_addr(query_addr), .out_a3(out_a3), .out_we(out_we), .out_tnew(out_tnew),
    .hit(hit), .hit_slot(hit_slot), .hit_ready(hit_ready)
`ifdef REGDST_PIPE_STATS_EN
    , .stat_bubbles(stat_bubbles), .stat_flushes(stat_flushes)
`endif
  );

  always #5 clk = ~clk;

  // Reference history: hist_*[k] = instruction that entered slot 0 k edges ago.
  int hist_a3 [ST];
  int hist_we [ST];
  int hist_t  [ST];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int k = 0; k < ST; k++) begin
      hist_a3[k] = 0; hist_we[k] = 0; hist_t[k] = 0;
    end
`ifdef REGDST_PIPE_STATS_EN
    m_bubbles = 0; m_flushes = 0;
`endif
  endtask

  // Effect of one rising edge with the inputs currently applied.
  task automatic model_edge();
    int a, w;
    if (!reset) begin
      model_clear();
      return;
    end
    case (in_regdst)
      2'd0: a = int'(in_rt);
      2'd1: a = int'(in_rd);
      2'd2: a = LINK;
      default: a = 0;
    endcase
    w = (in_valid && in_regdst != 2'd3 && a != 0) ? 1 : 0;
    if (flush) begin
      for (int k = 0; k < ST; k++) begin
        hist_a3[k] = 0; hist_we[k] = 0; hist_t[k] = 0;
      end
`ifdef REGDST_PIPE_STATS_EN
      m_flushes++;
`endif
    end else begin
      for (int k = ST - 1; k > 0; k--) begin
        hist_a3[k] = hist_a3[k-1]; hist_we[k] = hist_we[k-1]; hist_t[k] = hist_t[k-1];
      end
      if (stall) begin
        hist_a3[0] = 0; hist_we[0] = 0; hist_t[0] = 0;
`ifdef REGDST_PIPE_STATS_EN
        m_bubbles++;
`endif
      end else begin
        hist_a3[0] = a; hist_we[0] = w; hist_t[0] = int'(in_tnew);
      end
    end
  endtask

  task automatic check_all(input string ph);
    int eh, es, er, t;
    eh = 0; es = 0; er = 0;
    for (int k = 0; k < ST; k++) begin
      t = (hist_t[k] > k) ? hist_t[k] - k : 0;
      check($sformatf("%s a3[%0d]", ph, k), 32'(out_a3[k*AW +: AW]), 32'(hist_a3[k]));
      check($sformatf("%s we[%0d]", ph, k), 32'(out_we[k]), 32'(hist_we[k]));
      check($sformatf("%s tnew[%0d]", ph, k), 32'(out_tnew[k*TW +: TW]), 32'(t));
    end
    for (int k = ST - 1; k >= 0; k--) begin
      if (query_addr != 0 && hist_we[k] == 1 && hist_a3[k] == int'(query_addr)) begin
        eh = 1; es = k; er = (hist_t[k] <= k) ? 1 : 0;
      end
    end
    check({ph, " hit"}, 32'(hit), 32'(eh));
    check({ph, " hit_slot"}, 32'(hit_slot), 32'(es));
    check({ph, " hit_ready"}, 32'(hit_ready), 32'(er));
`ifdef REGDST_PIPE_STATS_EN
    check({ph, " stat_bubbles"}, stat_bubbles, m_bubbles);
    check({ph, " stat_flushes"}, stat_flushes, m_flushes);
`endif
  endtask

  task automatic drive(input logic v, input logic [1:0] m, input int rt, input int rd,
                       input int tn, input logic st, input logic fl);
    in_valid = v; in_regdst = m; in_rt = AW'(rt); in_rd = AW'(rd);
    in_tnew = TW'(tn); stall = st; flush = fl;
  endtask

  task automatic tick(input string ph);
    @(posedge clk);
    model_edge();
    #1;
    check_all(ph);
  endtask

  task automatic randomize_inputs();
    drive($urandom_range(0, 1), 2'($urandom_range(0, 3)), $urandom_range(0, 7),
          $urandom_range(0, 7), $urandom_range(0, 3),
          ($urandom_range(0, 5) == 0), ($urandom_range(0, 11) == 0));
    query_addr = AW'($urandom_range(0, 7));
  endtask

  initial begin
    model_clear();
    // Reset held with inputs toggling
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      randomize_inputs();
      tick("reset_hold");
    end
    // Release and track one mode-1 instruction to W
    drive(1'b0, 2'd3, 0, 0, 0, 1'b0, 1'b0);
    query_addr = AW'(8);
    @(negedge clk);
    reset = 1'b1;
    drive(1'b1, 2'd1, 3, 8, 2, 1'b0, 1'b0);
    tick("first");
    check("first slot0 a3", 32'(out_a3[0 +: AW]), 32'd8);
    check("first slot0 tnew", 32'(out_tnew[0 +: TW]), 32'd2);
    drive(1'b0, 2'd3, 0, 0, 0, 1'b0, 1'b0);
    tick("first+1");
    check("first slot1 tnew", 32'(out_tnew[TW +: TW]), 32'd1);
    tick("first+2");
    check("first slot2 tnew", 32'(out_tnew[2*TW +: TW]), 32'd0);
    check("first W ready", 32'(hit_ready), 32'd1);
    // Mode coverage, then mode 0 writing $0
    for (int m = 0; m < 4; m++) begin
      drive(1'b1, 2'(m), 5, 9, 1, 1'b0, 1'b0);
      query_addr = AW'($urandom_range(0, 31));
      tick($sformatf("mode%0d", m));
    end
    drive(1'b1, 2'd0, 0, 9, 1, 1'b0, 1'b0);
    tick("rt_zero");
    // Forward priority: two writers of r4, youngest not ready yet
    drive(1'b1, 2'd0, 4, 0, 1, 1'b0, 1'b0);
    tick("fwd_a");
    tick("fwd_b");
    query_addr = AW'(4);
    #1 check_all("fwd_q4");
    check("fwd youngest slot", 32'(hit_slot), 32'd0);
    query_addr = AW'(7);
    #1 check_all("fwd_q7");
    // Single stall, then three stalls drain the pipe
    drive(1'b1, 2'd1, 0, 12, 3, 1'b0, 1'b0);
    tick("pre_stall");
    drive(1'b1, 2'd1, 0, 13, 3, 1'b1, 1'b0);
    tick("stall1");
    tick("stall2");
    tick("stall3");
    check("drained we", 32'(out_we), 32'd0);
    // Flush together with stall and a valid input
    drive(1'b1, 2'd1, 0, 14, 2, 1'b0, 1'b0);
    tick("pre_flush_a");
    tick("pre_flush_b");
    drive(1'b1, 2'd1, 0, 15, 2, 1'b1, 1'b1);
    tick("flush_stall");
    check("flush a3 bus", 32'(out_a3), 32'd0);
    // Randomised stream
    for (int i = 0; i < 400; i++) begin
      randomize_inputs();
      tick("rand");
    end
    // Asynchronous reset between edges with three live slots
    for (int i = 0; i < ST; i++) begin
      drive(1'b1, 2'd1, 0, 20 + i, 3, 1'b0, 1'b0);
      tick("refill");
    end
    #2 reset = 1'b0;
    model_clear();
    query_addr = AW'(20);
    #1 check_all("async_rst");
    check("async_rst we bus", 32'(out_we), 32'd0);
    drive(1'b1, 2'd1, 0, 21, 1, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    query_addr = AW'(21);
    tick("post_rst");
    for (int i = 0; i < 50; i++) begin
      randomize_inputs();
      tick("rand2");
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=completion");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/regdst_pipe_tracker.md
Name: regdst_pipe_tracker

Overview:
- Parametrised successor to the execute-stage destination mux: decodes the write-destination register from the RegDst mode, then carries it with write-enable and Tnew through STAGES pipeline slots (E, M, W by default).
- Gives the hazard unit per-stage destination and Tnew state.
- Provides a combinational forwarding lookup with priority to the youngest stage.
- Replaces the separate per-stage A3 registers in the E/M/W pipeline registers.

Parameters:
- ADDR_W, 5, register-address width.
- STAGES, 3, tracked pipeline slots; slot 0 = E, slot STAGES-1 = W; legal range 2..8.
- TNEW_W, 2, Tnew field width.
- LINK_REG, 31, destination used by mode 2 (jal/jalr link).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low; 0 = reset.
- stall  in  1  D-stage stall; a bubble enters slot 0 this cycle.
- flush  in  1  clears every slot on the next edge.
- in_valid  in  1  the instruction leaving D is real.
- in_regdst  in  2  0=rt, 1=rd, 2=LINK_REG, 3=no write.
- in_rt  in  ADDR_W  rt field.
- in_rd  in  ADDR_W  rd field.
- in_tnew  in  TNEW_W  cycles until the result exists, counted from entry to slot 0.
- query_addr  in  ADDR_W  register being read by the consumer (forward lookup).
- out_a3  out  STAGES*ADDR_W  per-slot destination; slot i at bits [i*ADDR_W +: ADDR_W].
- out_we  out  STAGES  per-slot write enable.
- out_tnew  out  STAGES*TNEW_W  per-slot remaining Tnew.
- hit  out  1  query_addr matches a writing slot.
- hit_slot  out  3  index of the youngest matching slot.
- hit_ready  out  1  the matching slot's Tnew==0, so the value can be forwarded.

Behaviour:
- Reset (reset=0, asynchronous): all out_a3=0, out_we=0, out_tnew=0. hit/hit_ready/hit_slot evaluate to 0.
- Destination decode (combinational, slot-0 input):
  - a3 = rt / rd / LINK_REG / 0 by mode.
  - we = in_valid & (mode!=3) & (a3!=0).
  - Writes to $0 never assert we; a3 is still recorded.
- Each rising edge, priority flush > stall > normal:
  - flush=1: every slot cleared to a3=0, we=0, tnew=0. The incoming instruction is dropped.
  - stall=1: slot 0 loads a bubble (a3=0, we=0, tnew=0). Slots 1..STAGES-1 shift normally.
  - normal: slot 0 loads the decoded a3/we and tnew=in_tnew. Slots 1..STAGES-1 shift normally.
  - Shift: slot i+1 <= slot i, with tnew_next = (tnew==0) ? 0 : tnew-1 (saturates at 0, never wraps). The contents of slot STAGES-1 are discarded.
- Latency: one cycle from D inputs to slot 0. Slot k holds the instruction k+1 edges after capture.
- Forward lookup (combinational):
  - Scan slot 0 upward; the first slot with we=1 and a3==query_addr wins.
  - hit=1, hit_slot=index, hit_ready=(tnew of that slot==0).
  - No match, or query_addr==0: hit=0, hit_slot=0, hit_ready=0.
- in_tnew wider values saturate naturally; in_tnew=0 means slot 0 is immediately forwardable.
- Reset asserted mid-operation clears all slots immediately, without waiting for clk. Release is synchronous to the next edge.

Optional Feature:
- Macro REGDST_PIPE_STATS_EN.
- When defined:
  - Adds output stat_bubbles (32 bits), incremented on each edge with stall=1 & flush=0.
  - Adds output stat_flushes (32 bits), incremented on each edge with flush=1.
  - Both wrap from 0xFFFFFFFF to 0 and reset to 0.
- When undefined: neither port nor counter exists; remaining behaviour is identical.

Test Plan:
- Reset: hold reset=0 with random inputs toggling -> all outputs 0. Release, feed mode 1 with rd=8, tnew=2 -> after 1 edge slot0 a3=8, we=1, tnew=2. After 2 edges slot1 tnew=1. After 3 edges slot2 tnew=0.
- Mode coverage: modes 0/1/2/3 with rt=5, rd=9 -> slot0 a3 = 5/9/31/0, we = 1/1/1/0. Mode 0 with rt=0 -> a3=0, we=0.
- Forward priority: slot0 a3=4 tnew=1 and slot1 a3=4 tnew=0, query 4 -> hit=1, hit_slot=0, hit_ready=0. Query 7 -> hit=0.
- Stall: stall=1 on one cycle -> slot0 becomes a bubble and prior slot0 moves to slot1. Three consecutive stalls -> pipeline drains to all we=0.
- Flush and stall together: flush=1 with stall=1 and a valid input -> all slots clear. With stats enabled, stat_flushes=1 and stat_bubbles unchanged.
- Async reset mid-stream: drop reset between clock edges with 3 valid slots -> outputs are 0 before the next clk edge.
